// File: rtl/nibble_stream_pkg.sv
// Shared constants, serialiser state type and nibble helper for the nibble stream transmitter.
package nibble_stream_pkg;

    localparam int NIB_W     = 4;
    localparam int BYTE_W    = 8;
    localparam int GAP_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        NIB1,
        GAP1,
        NIB2,
        GAP2
    } ser_state_e;

    function automatic logic [NIB_W-1:0] pick_nibble(input logic [BYTE_W-1:0] b, input logic high);
        return high ? b[BYTE_W-1:NIB_W] : b[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/nibble_stream_tx_if.sv
// Byte-side handshake plus the nibble-side {toggle, valid, din} bus of the transmitter.
interface nibble_stream_tx_if;
    import nibble_stream_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [NIB_W-1:0]  din;
    logic              valid;
    logic              toggle;
    logic              busy;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, din, valid, toggle, busy
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, din, valid, toggle, busy
    );

endinterface

// File: rtl/nibble_stream_tx_fifo.sv
// Small power-of-two byte FIFO with registered count; push is ignored when full, pop when empty.
module byte_fifo
    import nibble_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [BYTE_W-1:0]              wr_data,
    output logic [BYTE_W-1:0]              rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full/empty come straight from the registered count, so a pop never frees a slot in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/nibble_stream_tx.sv
// Buffers bytes and serialises each into two valid-qualified nibbles with optional idle gaps.
module nibble_stream_tx
    import nibble_stream_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    nibble_stream_tx_if.slave bus
);
    localparam int                   CNT_W      = $clog2(DEPTH + 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD   = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic                 FIRST_HIGH = (MSB_FIRST != 0);

    ser_state_e         state;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [BYTE_W-1:0]  cur_byte;
    logic [NIB_W-1:0]   din_r;
    logic               valid_r;
    logic               toggle_r;
    logic               busy_r;

    logic [BYTE_W-1:0]  fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.byte_valid),
        .pop     (pop),
        .wr_data (bus.byte_in),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A new byte is taken from IDLE or on the final cycle of a byte, so queued bytes stream without a bubble.
    assign pop = !fifo_empty &&
                 ((state == IDLE) ||
                  (state == GAP2 && gap_cnt == '0) ||
                  (GAP == 0 && state == NIB2));

    assign bus.byte_ready = !fifo_full;
    assign bus.din        = din_r;
    assign bus.valid      = valid_r;
    assign bus.toggle     = toggle_r;
    assign bus.busy       = busy_r;

    // Outputs are registered from the current state, so they show one cycle after the state is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            cur_byte <= '0;
            din_r    <= '0;
            valid_r  <= 1'b0;
            toggle_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            busy_r  <= (state != IDLE) || (fifo_count != '0);
            valid_r <= 1'b0;
            din_r   <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_byte <= fifo_rd;
                        state    <= NIB1;
                    end
                end
                NIB1: begin
                    valid_r <= 1'b1;
                    din_r   <= pick_nibble(cur_byte, FIRST_HIGH);
                    if (GAP == 0) begin
                        state <= NIB2;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP1;
                    end
                end
                GAP1: begin
                    if (gap_cnt == '0) begin
                        state <= NIB2;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_CNT_W'(1);
                    end
                end
                NIB2: begin
                    valid_r  <= 1'b1;
                    din_r    <= pick_nibble(cur_byte, !FIRST_HIGH);
                    toggle_r <= ~toggle_r;
                    if (GAP != 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP2;
                    end else if (pop) begin
                        cur_byte <= fifo_rd;
                        state    <= NIB1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP2: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_CNT_W'(1);
                    end else if (pop) begin
                        cur_byte <= fifo_rd;
                        state    <= NIB1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
